// File: rtl/sdram_cpu_bridge.sv
// rtl/sdram_cpu_bridge.sv - PicoRV32 native bus to Wishbone-classic SDRAM port bridge
// Registers every request, turns partial-strobe stores into read-modify-write, and times out stalled phases.
module sdram_cpu_bridge #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    input  logic              wb_ack_i,
    output logic              busy,
    output logic [7:0]        err_count
);
    typedef enum logic [2:0] {IDLE, RD, GAP, WR, RESP} state_t;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        err_q, err_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [31:0]       merged;
    logic [7:0]        err_inc;
    logic              expired;
    logic              unused_addr;

    assign unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
    assign expired     = (cnt_q == LAST_CNT);
    assign err_inc     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    // Until the read returns, data_q still holds the CPU write data, so the merge needs no extra register.
    always_comb begin
        merged = wb_dat_i;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = data_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        data_d  = data_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    adr_d   = cpu_addr[ADDR_W+1:2];
                    data_d  = cpu_wdata;
                    wstrb_d = cpu_wstrb;
                    cnt_d   = 16'd0;
                    cyc_d   = 1'b1;
                    we_d    = (cpu_wstrb == 4'hF);
                    state_d = (cpu_wstrb == 4'hF) ? WR : RD;
                end
            end
            RD: begin
                if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    if (|wstrb_q) begin
                        data_d  = merged;
                        state_d = GAP;
                    end else begin
                        data_d  = wb_dat_i;
                        ready_d = 1'b1;
                        state_d = RESP;
                    end
                end else if (expired) begin
                    cyc_d   = 1'b0;
                    err_d   = err_inc;
                    data_d  = ERR_DATA;
                    ready_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                cnt_d   = 16'd0;
                state_d = WR;
            end
            WR: begin
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    state_d = RESP;
                end else if (expired) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = err_inc;
                    data_d  = ERR_DATA;
                    ready_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            adr_q   <= '0;
            data_q  <= 32'd0;
            wstrb_q <= 4'd0;
            cnt_q   <= 16'd0;
            err_q   <= 8'd0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign cpu_ready = ready_q;
    assign cpu_rdata = data_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = data_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign busy      = busy_q;
    assign err_count = err_q;
endmodule

// File: doc/sdram_cpu_bridge.md
# sdram_cpu_bridge

Single-clock bridge between the PicoRV32 native memory bus and the Wishbone-classic SDRAM controller port (word-addressed, no byte selects). It sits directly upstream of the SDRAM controller, in the CPU clock domain. It registers every transaction and turns partial-strobe writes into read-modify-write sequences, so that byte and halfword stores do not corrupt neighbouring bytes. A timeout returns a fixed error word if the controller never acknowledges, so the CPU cannot hang.

## Interface
- ADDR_W, 20, Wishbone word-address width; `wb_adr_o = cpu_addr[ADDR_W+1:2]`
- TIMEOUT, 255, cycles a Wishbone phase may wait for ack (≥2, ≤65535)
- ERR_DATA, 32'hDEAD_BEEF, `cpu_rdata` value returned on timeout

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_valid  in  1  request; held until `cpu_ready`
- cpu_addr  in  32  byte address (bits [1:0] ignored)
- cpu_wdata  in  32  write data
- cpu_wstrb  in  4  byte strobes; 0 = read
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while `cpu_ready`=1
- wb_adr_o  out  ADDR_W  word address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data, sampled when `wb_ack_i`=1
- wb_cyc_o, wb_stb_o  out  1  driven identically
- wb_we_o  out  1  write phase
- wb_ack_i  in  1  slave acknowledge
- busy  out  1  state ≠ IDLE
- err_count  out  8  saturating timeout counter

## Operation
- States: IDLE, RD, GAP, WR, RESP.
- IDLE: when `cpu_valid`=1, latch the address, wdata and wstrb.
  - wstrb=0 → RD.
  - wstrb=4'hF → WR.
  - Any other non-zero wstrb → RD (RMW flag set).
- RD: assert cyc/stb with `we`=0. On ack, capture `wb_dat_i` into the data register.
  - Plain read → RESP.
  - RMW → merge: for each byte i, `data[8i+7:8i] = wstrb[i] ? wdata byte : read byte`; then → GAP.
- GAP: one cycle with cyc/stb low, so the controller sees a distinct new transaction; then → WR.
- WR: assert cyc/stb/we, with `wb_dat_o` = data register (merged data, or the full wdata). On ack → RESP.
- RESP: `cpu_ready`=1 for exactly one cycle; then → IDLE unconditionally.
  - `cpu_rdata` = captured word for reads, `ERR_DATA` after a timeout, and the last data register value for writes (the CPU ignores it).
- Timeout: the phase counter clears on entry to RD/WR and increments each cycle without ack.
  - When the counter reaches TIMEOUT-1 with no ack: drop cyc/stb, increment `err_count` (saturating at 255), load `ERR_DATA`, → RESP.
  - A timed-out RMW read skips the write phase entirely.
- Ack in the same cycle as timeout expiry: ack wins; no error is counted.
- `wb_ack_i` outside RD/WR is ignored.
- A `cpu_valid` drop mid-transaction is not legal PicoRV32 behaviour. The bridge still completes the Wishbone phase.
- `cpu_addr` bits above ADDR_W+1 are ignored; decoding is done externally.

## Timing
- Reset values:
  - state=IDLE
  - `cpu_ready`=0, `cpu_rdata`=0
  - `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0
  - `wb_adr_o`=0, `wb_dat_o`=0
  - `busy`=0, `err_count`=0
- Reset mid-transaction: the state returns to IDLE and cyc/stb drop at the next edge.
- All outputs are registered; there is no combinational path from any input to any output.
- Request sampled at edge 0 → cyc/stb high from cycle 1.
- Ack high in cycle n → cyc/stb low in cycle n+1.
  - Read or full write: `cpu_ready` high in cycle n+1.
  - RMW: GAP in cycle n+1, WR cyc high from cycle n+2, write ack in cycle m → `cpu_ready` in cycle m+1.
- With a zero-wait slave (ack in cycle 1): read/full-write latency is 2 cycles from the valid edge to `cpu_ready`; RMW latency is 4.
- Back-to-back requests: a new request is accepted in the IDLE cycle right after RESP; no further bubble is added.

## Test plan
- Read: valid, addr=0x0300_0010, wstrb=0, slave acks in the 3rd cyc cycle with 0x1234_5678 → `wb_adr_o`=4, `we`=0, `cpu_ready` one cycle later with `cpu_rdata`=0x1234_5678, exactly one pulse.
- Full write: wstrb=F, wdata=0xCAFE_F00D → a single WR phase with `wb_dat_o`=0xCAFE_F00D, no RD phase, `cpu_ready` one cycle after ack.
- Byte RMW: memory word 0xAABB_CCDD, wstrb=0010, wdata=0x0000_5500 → RD, then one GAP cycle with cyc low, then WR with data 0xAABB_55DD; halfword wstrb=1100, wdata=0x1122_0000 → 0x1122_CCDD.
- Timeout: TIMEOUT=8 and the slave never acks → cyc high for exactly 8 cycles, `cpu_rdata`=0xDEAD_BEEF, `err_count`=1. A timed-out RMW produces no WR phase; 300 timeouts leave `err_count`=255.
- Ack on the last timeout cycle → normal data is returned and `err_count` is unchanged.
- Reset asserted during WR → cyc/stb/we are 0 and `busy`=0 the next cycle; `cpu_ready` never pulses; the next read completes normally.
